vc_mem_arbiter: RTL
===================

Name: vc_mem_arbiter

Overview:
Shares the single off-chip memory port between two requesters: L1 line fills (reads) and victim-cache dirty write-backs (writes). It grants one requester at a time and runs one transaction at a time (issue, then wait for response). The response is routed back to the owning requester. Arbitration is L1-priority, with two exceptions: a starvation limit protects the VC, and a same-tag hazard rule makes the VC write-back go first so a fill never reads stale memory. The block sits between the L1 controller, the victim_cache_controller memory interface and the memory model/bus.

Parameters:
TAG_WIDTH, 20, line address width (L1 tag+index), same as the VC.
LINE_BYTES, 16, line size in bytes; the data buses are LINE_BYTES*8 bits wide.
STARVE_LIMIT, 4, maximum consecutive L1 grants while the VC is waiting; range 1..15.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
l1_req  in  1  L1 fill request; level signal, held until l1_resp_valid
l1_tag  in  TAG_WIDTH  fill line address; stable while l1_req is high
l1_resp_valid  out  1  one-cycle pulse, fill data valid
l1_resp_rdata  out  LINE_BYTES*8  fill data
vc_req  in  1  VC write-back request; level signal, held until vc_resp_valid
vc_tag  in  TAG_WIDTH  write-back line address
vc_wdata  in  LINE_BYTES*8  write-back data
vc_resp_valid  out  1  one-cycle pulse, write-back completed
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts the request
mem_req_write  out  1  1 = write, 0 = read
mem_req_tag  out  TAG_WIDTH  request address
mem_req_wdata  out  LINE_BYTES*8  write data (0 on reads)
mem_resp_valid  in  1  memory response/completion; one-cycle pulse
mem_resp_rdata  in  LINE_BYTES*8  read data
busy  out  1  high in any state other than S_IDLE
owner  out  1  current grant, 0 = L1, 1 = VC; valid while busy

Behaviour:
- Reset (asynchronous): state = S_IDLE, owner = 0, starve_cnt = 0. All outputs are 0.
- An outstanding memory transaction is abandoned on reset. Memory-side reset is the system's responsibility.
- States: S_IDLE, S_ISSUE, S_WAIT.
- S_IDLE, with no request: stay in S_IDLE.
- S_IDLE, arbitration on l1_req/vc_req:
  - Only one request high: grant it.
  - Both high and l1_tag == vc_tag (hazard): grant VC.
  - Both high and starve_cnt == STARVE_LIMIT: grant VC.
  - Both high otherwise: grant L1.
- On any grant: register owner, go to S_ISSUE. Latency from a request in S_IDLE to mem_req_valid is 1 cycle.
- starve_cnt, updated on each grant:
  - L1 granted while vc_req is high: increment, saturating at STARVE_LIMIT.
  - VC granted, or L1 granted with vc_req low: clear to 0.
  - Counter width: 4 bits.
- S_ISSUE:
  - mem_req_valid = 1. mem_req_tag and mem_req_wdata are driven combinationally from the owner's inputs.
  - mem_req_write = owner. mem_req_wdata = 0 when owner = L1.
  - Hold until mem_req_ready, then go to S_WAIT. Back-pressure of any length is legal.
- S_WAIT:
  - mem_req_valid = 0.
  - On mem_resp_valid: pulse the owner's resp_valid in the same cycle (combinational pass-through).
  - l1_resp_rdata = mem_resp_rdata while owner = L1 and mem_resp_valid; otherwise 0.
  - Next state is S_IDLE.
- mem_resp_valid outside S_WAIT is ignored. Memory guarantees the response comes at least 1 cycle after acceptance.
- Requester contract: the requester drops req in the cycle after its resp pulse. The arbiter therefore never re-grants a completed request.
- Back-to-back transactions: minimum 3 cycles per transaction (IDLE, ISSUE, WAIT with ready and resp each arriving after 1 cycle).
- A request dropped by its requester before grant is legal and is not serviced. Dropping after grant is illegal (assertion).
- A request arriving in any state other than S_IDLE waits; no queueing beyond the level req.
- Never a grant in the same cycle as a response. Only one owner at a time.

Test Plan:
- Single L1 fill: l1_req=1, l1_tag=0x00ABC; mem ready after 2 cycles; resp with rdata=0xDEAD..BEEF 3 cycles later -> mem_req_write=0, mem_req_tag=0x00ABC, l1_resp_valid pulses once with that data, vc_resp_valid stays 0, busy falls the next cycle.
- Single VC write-back: vc_req=1, vc_tag=0x12345, wdata=0x11..11 -> mem_req_write=1 with tag and wdata matched; vc_resp_valid pulses exactly on mem_resp_valid.
- Simultaneous requests, distinct tags (l1_tag=0x1, vc_tag=0x2) -> L1 granted first, VC granted right after the L1 response; starve_cnt returns to 0.
- Hazard: both requests with tag 0x00777 -> VC write granted first, L1 read issued second.
- Starvation: VC held high while L1 re-requests continuously, STARVE_LIMIT=4 -> exactly 4 L1 grants, then a VC grant, then L1 again.
- Reset mid-S_WAIT: assert rst_n=0 -> busy, mem_req_valid and resp outputs go to 0 immediately. A stale mem_resp_valid after reset produces no resp pulse.

Source files
------------

// File: rtl/vc_mem_arbiter_if.sv
// rtl/vc_mem_arbiter_if.sv - off-chip memory port shared by L1 fills and VC write-backs
interface vc_mem_arbiter_if #(
    parameter int TAG_WIDTH  = 20,
    parameter int LINE_BYTES = 16
) ();
    logic                    mem_req_valid;
    logic                    mem_req_ready;
    logic                    mem_req_write;
    logic [TAG_WIDTH-1:0]    mem_req_tag;
    logic [LINE_BYTES*8-1:0] mem_req_wdata;
    logic                    mem_resp_valid;
    logic [LINE_BYTES*8-1:0] mem_resp_rdata;

    modport master (
        output mem_req_valid, mem_req_write, mem_req_tag, mem_req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_req_write, mem_req_tag, mem_req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata
    );
endinterface

// File: rtl/vc_mem_arbiter.sv
// rtl/vc_mem_arbiter.sv - L1-priority memory arbiter with VC starvation limit and same-tag hazard ordering
module vc_mem_arbiter #(
    parameter int TAG_WIDTH    = 20,
    parameter int LINE_BYTES   = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    l1_req,
    input  logic [TAG_WIDTH-1:0]    l1_tag,
    output logic                    l1_resp_valid,
    output logic [LINE_BYTES*8-1:0] l1_resp_rdata,
    input  logic                    vc_req,
    input  logic [TAG_WIDTH-1:0]    vc_tag,
    input  logic [LINE_BYTES*8-1:0] vc_wdata,
    output logic                    vc_resp_valid,
    vc_mem_arbiter_if.master        mem,
    output logic                    busy,
    output logic                    owner
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2} state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t     state, state_nxt;
    logic       owner_nxt;
    logic [3:0] starve_cnt, starve_nxt;
    logic       grant_vc;
    logic       issue, resp_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            owner      <= 1'b0;
            starve_cnt <= 4'd0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        starve_nxt = starve_cnt;
        grant_vc   = 1'b0;
        case (state)
            S_IDLE: begin
                if (l1_req || vc_req) begin
                    // VC wins a tie on a matching tag so the fill never reads stale memory
                    grant_vc  = vc_req && (!l1_req || (l1_tag == vc_tag) || (starve_cnt == STARVE_MAX));
                    owner_nxt = grant_vc;
                    state_nxt = S_ISSUE;
                    if (!grant_vc && vc_req)
                        starve_nxt = (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + 4'd1;
                    else
                        starve_nxt = 4'd0;
                end
            end
            S_ISSUE: if (mem.mem_req_ready)  state_nxt = S_WAIT;
            S_WAIT:  if (mem.mem_resp_valid) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign issue    = (state == S_ISSUE);
    assign resp_hit = (state == S_WAIT) && mem.mem_resp_valid;

    assign mem.mem_req_valid = issue;
    assign mem.mem_req_write = issue && owner;
    assign mem.mem_req_tag   = !issue ? '0 : (owner ? vc_tag : l1_tag);
    assign mem.mem_req_wdata = (issue && owner) ? vc_wdata : '0;

    assign l1_resp_valid = resp_hit && !owner;
    assign vc_resp_valid = resp_hit && owner;
    assign l1_resp_rdata = l1_resp_valid ? mem.mem_resp_rdata : '0;
    assign busy          = (state != S_IDLE);

    a_l1_hold: assert property (@(posedge clk) disable iff (!rst_n)
        ((state != S_IDLE) && !owner) |-> l1_req);
    a_vc_hold: assert property (@(posedge clk) disable iff (!rst_n)
        ((state != S_IDLE) && owner) |-> vc_req);
endmodule
